// File: rtl/event_drain_master_if.sv
// Bus and stream bundle for event_drain_master.
//   bus_wr/bus_rd/bus_addr/bus_wdata : register strobes toward the monitor
//   bus_rdata                        : monitor read data, valid the cycle after bus_rd
//   m_valid/m_data/m_last/m_ready    : outgoing 32-bit event word stream
// master = the drain engine, slave = monitor plus downstream sink.
interface event_drain_master_if;
    logic        bus_wr;
    logic        bus_rd;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    modport master (
        output bus_wr, bus_rd, bus_addr, bus_wdata, m_valid, m_data, m_last,
        input  bus_rdata, m_ready
    );

    modport slave (
        input  bus_wr, bus_rd, bus_addr, bus_wdata, m_valid, m_data, m_last,
        output bus_rdata, m_ready
    );
endinterface

// File: rtl/event_drain_master.sv
// Drains event records from a trace monitor's register window and replays
// them as a 32-bit word stream.
//   clk, rst  : clock, synchronous active-high reset
//   en        : drain enable
//   bus       : event_drain_master_if.master (register bus + output stream)
//   evt_count : events fully delivered (wraps)
//   busy      : high whenever the engine is not idle
// Every output is a register loaded from the next-state decode, so strobes
// and stream signals line up exactly with the state they belong to.
module event_drain_master #(
    parameter int         PROBE_W     = 32,
    parameter int         ID_W        = 8,
    parameter int         TS_W        = 32,
    parameter logic [7:0] STATUS_ADDR = 8'h0C,
    parameter logic [7:0] EVT_ADDR    = 8'h10,
    parameter logic [7:0] POP_ADDR    = 8'h1C,
    parameter int         POLL_GAP    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    event_drain_master_if.master        bus,
    output logic [15:0]                 evt_count,
    output logic                        busy
);
    localparam int REC_W  = TS_W + ID_W + PROBE_W;
    localparam int NWORDS = (REC_W + 31) / 32;
    localparam int PAD    = NWORDS * 32 - REC_W;
    // Bits above REC_W in the top word are forced to zero on capture.
    localparam logic [31:0] TOP_MASK = 32'hFFFF_FFFF >> PAD;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, POLL, POLL_WAIT, RD, RD_WAIT, POP, SEND, GAP
    } state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         idx, idx_n;
    logic [GAP_W-1:0]         gap_cnt, gap_n;
    logic [NWORDS-1:0][31:0]  buffer, buf_n;
    logic [15:0]              cnt_n;
    logic                     rd_n, wr_n, mv_n, ml_n, busy_n;
    logic [7:0]               addr_n;
    logic [31:0]              wdata_n, md_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        gap_n   = gap_cnt;
        buf_n   = buffer;
        cnt_n   = evt_count;

        case (state)
            IDLE:      if (en) state_n = POLL;
            POLL:      state_n = POLL_WAIT;
            POLL_WAIT: begin
                if (bus.bus_rdata[0]) begin
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    state_n = RD;
                    idx_n   = '0;
                end
            end
            RD:        state_n = RD_WAIT;
            RD_WAIT: begin
                if (idx == LAST_IDX) begin
                    buf_n[idx] = bus.bus_rdata & TOP_MASK;
                    state_n    = POP;
                end else begin
                    buf_n[idx] = bus.bus_rdata;
                    idx_n      = idx + IDX_W'(1);
                    state_n    = RD;
                end
            end
            POP: begin
                state_n = SEND;
                idx_n   = '0;
            end
            SEND: begin
                // en is deliberately ignored until the last word is taken.
                if (bus.m_valid && bus.m_ready) begin
                    if (idx == LAST_IDX) begin
                        cnt_n   = evt_count + 16'd1;
                        idx_n   = '0;
                        state_n = en ? POLL : IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                if (!en) begin
                    state_n = IDLE;
                    gap_n   = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_n = POLL;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default:   state_n = IDLE;
        endcase

        // Output decode from the next state keeps all outputs registered.
        rd_n    = (state_n == POLL) || (state_n == RD);
        wr_n    = (state_n == POP);
        case (state_n)
            POLL:    addr_n = STATUS_ADDR;
            RD:      addr_n = EVT_ADDR + 8'({idx_n, 2'b00});
            POP:     addr_n = POP_ADDR;
            default: addr_n = 8'h00;
        endcase
        wdata_n = wr_n ? 32'h1 : 32'h0;
        mv_n    = (state_n == SEND);
        md_n    = mv_n ? buf_n[idx_n] : 32'h0;
        ml_n    = mv_n && (idx_n == LAST_IDX);
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            gap_cnt       <= '0;
            buffer        <= '0;
            evt_count     <= 16'h0;
            busy          <= 1'b0;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_addr  <= 8'h0;
            bus.bus_wdata <= 32'h0;
            bus.m_valid   <= 1'b0;
            bus.m_data    <= 32'h0;
            bus.m_last    <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            gap_cnt       <= gap_n;
            buffer        <= buf_n;
            evt_count     <= cnt_n;
            busy          <= busy_n;
            bus.bus_rd    <= rd_n;
            bus.bus_wr    <= wr_n;
            bus.bus_addr  <= addr_n;
            bus.bus_wdata <= wdata_n;
            bus.m_valid   <= mv_n;
            bus.m_data    <= md_n;
            bus.m_last    <= ml_n;
        end
    end
endmodule

// File: tb/tb_event_drain_master.sv
// Bench for event_drain_master: monitor register model, directed scenarios,
// and a negedge compare process driven by a protocol-level model.
module tb_event_drain_master;
    localparam int NW = 3;

    logic        clk, rst, en;
    logic [15:0] evt_count;
    logic        busy;

    event_drain_master_if bif();

    event_drain_master dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bif),
        .evt_count (evt_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    // monitor FIFO contents: written by stimulus, head advanced by responder
    logic [31:0] ev_ts [0:15];
    logic [7:0]  ev_id [0:15];
    logic [31:0] ev_d  [0:15];
    int          ev_wr = 0;
    int          ev_rd = 0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          timeouts = 0;
    logic [15:0] cnt_base = 16'h0;
    bit          final_req = 1'b0;

    function automatic logic [31:0] rec_word(input logic [31:0] ts, input logic [7:0] id,
                                             input logic [31:0] d, input int k);
        logic [95:0] r;
        r = {24'h0, ts, id, d};
        return r[k*32 +: 32];
    endfunction

    // Monitor register responder; junk above the record in the top word
    always @(posedge clk) begin : responder
        int          k;
        logic [31:0] w;
        bif.bus_rdata <= 32'h0;
        if (bif.bus_rd) begin
            if (bif.bus_addr == 8'h0C)
                bif.bus_rdata <= {31'd0, ev_rd == ev_wr};
            else if (ev_rd != ev_wr && bif.bus_addr >= 8'h10 && bif.bus_addr <= 8'h18) begin
                k = (int'(bif.bus_addr) - 16) / 4;
                w = rec_word(ev_ts[ev_rd], ev_id[ev_rd], ev_d[ev_rd], k);
                if (k == 2) w = w | 32'hAB00_0000;
                bif.bus_rdata <= w;
            end
        end
        if (bif.bus_wr && bif.bus_addr == 8'h1C && bif.bus_wdata == 32'h1 && ev_rd != ev_wr)
            ev_rd <= ev_rd + 1;
    end

    // ---------------- compare process ----------------
    logic [7:0]  lit_addr [0:4] = '{8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    logic [31:0] lit_word [0:2] = '{32'hDEAD_BEEF, 32'h0001_0005, 32'h0000_0000};
    logic [2:0]  lit_last = 3'b100;

    word_t exp_q[$];
    int    cyc = 0, delivered = 0, exp_k = -1, lit_n = 0, lit_w = 0, last_poll_cyc = 0;
    bit    rst_prev = 0, strobe_prev = 0, stall_prev = 0, poll_ok = 0, en_low_seen = 0;
    bit    parked = 0, wrap_pend = 0, lit1_pend = 0, final_done = 0;
    logic [32:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : compare
        bit strobe;
        cyc++;
        strobe = bif.bus_rd || bif.bus_wr;
        if (rst_prev) begin
            chk("rst_flags", {bif.bus_wr, bif.bus_rd, bif.m_valid, bif.m_last, busy}, 0);
            chk("rst_addr_wdata", {bif.bus_addr, bif.bus_wdata}, 0);
            chk("rst_m_data", bif.m_data, 0);
            chk("rst_evt_count", evt_count, 0);
            exp_q.delete();
            delivered = 0; exp_k = -1; poll_ok = 0; parked = 0;
            stall_prev = 0; strobe_prev = 0; wrap_pend = 0;
        end else begin
            if (!en) en_low_seen = 1;
            chk("evt_count", evt_count, 16'(cnt_base + 16'(delivered)));
            if (lit1_pend) begin chk("lit_count_one", evt_count, 16'd1); lit1_pend = 0; end
            if (wrap_pend) begin chk("lit_count_wrap", evt_count, 16'd0); wrap_pend = 0; end
            if (parked) begin
                chk("parked_idle", {busy, strobe}, 0);
                if (en) parked = 0;
            end
            if (strobe_prev) chk("strobe_pulse", strobe, 0);
            if (!strobe) chk("bus_quiet", {bif.bus_addr, bif.bus_wdata}, 0);
            else begin
                chk("rd_wr_excl", bif.bus_rd && bif.bus_wr, 0);
                if (lit_n < 5) begin chk("lit_addr", bif.bus_addr, lit_addr[lit_n]); lit_n++; end
                if (exp_k < 0) begin
                    chk("poll_strobe", {bif.bus_wr, bif.bus_rd, bif.bus_addr}, {2'b01, 8'h0C});
                    if (poll_ok && !en_low_seen) chk("poll_spacing", cyc - last_poll_cyc, 18);
                    last_poll_cyc = cyc;
                    poll_ok       = (ev_rd == ev_wr);
                    en_low_seen   = !en;
                    exp_k         = (ev_rd == ev_wr) ? -1 : 0;
                end else if (exp_k < NW) begin
                    chk("evt_read", {bif.bus_wr, bif.bus_rd, bif.bus_addr},
                        {2'b01, 8'(16 + 4 * exp_k)});
                    exp_k++;
                end else begin
                    chk("pop_write", {bif.bus_wr, bif.bus_rd, bif.bus_addr, bif.bus_wdata},
                        {2'b10, 8'h1C, 32'h1});
                    for (int k = 0; k < NW; k++)
                        exp_q.push_back('{rec_word(ev_ts[ev_rd], ev_id[ev_rd], ev_d[ev_rd], k),
                                          k == NW - 1});
                    exp_k = -1;
                end
            end
            if (stall_prev) chk("stall_valid", bif.m_valid, 1);
            if (bif.m_valid) begin
                chk("valid_no_strobe", strobe, 0);
                chk("valid_busy", busy, 1);
                chk("valid_has_event", exp_q.size() > 0, 1);
                if (stall_prev) chk("stall_hold", {bif.m_last, bif.m_data}, held);
                if (exp_q.size() > 0) begin
                    chk("m_data", bif.m_data, exp_q[0].d);
                    chk("m_last", bif.m_last, exp_q[0].l);
                    if (bif.m_ready) begin
                        if (lit_w < 3) begin
                            chk("lit_word", bif.m_data, lit_word[lit_w]);
                            chk("lit_last", bif.m_last, lit_last[lit_w]);
                            lit_w++;
                            if (lit_w == 3) lit1_pend = 1;
                        end
                        if (exp_q[0].l) begin
                            delivered++;
                            if (!en) parked = 1;
                            if (evt_count == 16'hFFFF) wrap_pend = 1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            stall_prev  = bif.m_valid && !bif.m_ready;
            held        = {bif.m_last, bif.m_data};
            strobe_prev = strobe;
        end
        if (final_req && !final_done) begin
            chk("timeouts", timeouts, 0);
            final_done = 1;
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [31:0] ts, input logic [7:0] id, input logic [31:0] d);
        ev_ts[ev_wr] = ts; ev_id[ev_wr] = id; ev_d[ev_wr] = d;
        ev_wr++;
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (evt_count == v) return;
        end
        timeouts++;
        $display("FAIL wait_evt_count: got %0h want %0h", evt_count, v);
    endtask

    task automatic wait_rd_addr(input logic [7:0] a, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (bif.bus_rd && bif.bus_addr == a) return;
        end
        timeouts++;
        $display("FAIL wait_read: got addr %0h want %0h", bif.bus_addr, a);
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (bif.m_valid) return;
        end
        timeouts++;
        $display("FAIL wait_m_valid: got 0 want 1");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; bif.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // one event, free-flowing sink
        push(32'h0000_0100, 8'h05, 32'hDEAD_BEEF);
        en = 1'b1;
        wait_cnt(16'd1, 200);

        // empty monitor: periodic polls only
        repeat (60) @(posedge clk);
        #1;

        // sink stalls 10 cycles on word 1
        bif.m_ready = 1'b0;
        push(32'h1234_5678, 8'hA5, 32'h0BAD_F00D);
        wait_valid(200);
        bif.m_ready = 1'b1;
        @(posedge clk); #1;
        bif.m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 bif.m_ready = 1'b1;
        wait_cnt(16'd2, 200);

        // en dropped while reading word 1
        push(32'hCAFE_BABE, 8'h3C, 32'h1122_3344);
        wait_rd_addr(8'h14, 200);
        en = 1'b0;
        wait_cnt(16'd3, 200);
        repeat (30) @(posedge clk);
        #1;

        // reset during the word-2 read wait
        en = 1'b1;
        push(32'h00C0_FFEE, 8'h7E, 32'h55AA_55AA);
        wait_rd_addr(8'h18, 200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cnt(16'd1, 200);

        // counter wrap
        repeat (40) @(posedge clk);
        #1;
        force dut.evt_count = 16'hFFFF;
        cnt_base = 16'hFFFF - 16'(delivered);
        #1 release dut.evt_count;
        push(32'hFFFF_FFFF, 8'hFF, 32'h8000_0001);
        wait_cnt(16'd0, 200);
        repeat (5) @(posedge clk);

        final_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
